// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared types and helpers for the gate sweep checkers.
//   state_e     : sweep controller states.
//   MODE_*      : selectors for the expected reduction function.
//   MAX_N_IN    : widest gate supported by expect_bit.
//   expect_bit  : expected gate output for a vector. Inputs are the mode, the
//                 vector zero-extended to MAX_N_IN bits, and the real input count.
// -----------------------------------------------------------------------------
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_OR  = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_NOR = 2'd3;

    localparam int unsigned MAX_N_IN = 6;

    function automatic logic expect_bit(input logic [1:0]          mode,
                                        input logic [MAX_N_IN-1:0] vec,
                                        input int unsigned         n_in);
        logic [MAX_N_IN-1:0] pad;
        logic                res;
        // Bits above the real input count are zero in vec. For AND they are
        // forced to one so that they do not mask the reduction.
        pad = '0;
        for (int i = 0; i < MAX_N_IN; i++) begin
            if (i >= int'(n_in)) begin
                pad[i] = 1'b1;
            end
        end
        case (mode)
            MODE_OR:  res = |vec;
            MODE_AND: res = &(vec | pad);
            MODE_XOR: res = ^vec;
            default:  res = ~(|vec);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sweep_expect.sv
// -----------------------------------------------------------------------------
// sweep_expect
// Combinational reference for an N_IN-input reduction gate.
//   vec     (in,  N_IN) : input vector currently applied to the gate.
//   exp_bit (out, 1)    : output the gate should produce for vec under MODE.
// -----------------------------------------------------------------------------
module sweep_expect
    import sweep_pkg::*;
#(
    parameter int unsigned N_IN = 3,
    parameter int unsigned MODE = 0
) (
    input  logic [N_IN-1:0] vec,
    output logic            exp_bit
);

    always_comb begin
        exp_bit = expect_bit(MODE[1:0], MAX_N_IN'(vec), N_IN);
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// gate_sweep_checker
// Exhaustive stimulus and capture wrapper for a small combinational gate.
// A start pulse applies vectors 0..2^N_IN-1 in ascending order. Each vector is
// held for SETTLE cycles and the gate output is then sampled for one cycle.
// Each sample is compared with the expected function and stored in the
// captured truth table.
//   clk            (in)        : rising-edge clock.
//   rst            (in)        : synchronous, active-high reset.
//   start          (in)        : pulse that begins a sweep from IDLE or DONE.
//   gate_in        (out, N_IN) : vector driven onto the gate under test.
//   gate_out       (in)        : gate output, used only in the sample cycle.
//   busy           (out)       : high during a sweep.
//   done           (out)       : high in DONE.
//   pass           (out)       : in DONE, high when no vector mismatched.
//   err_count      (out, N_IN+1): number of mismatching vectors.
//   first_fail_vec (out, N_IN) : first mismatching vector.
//   fail_seen      (out)       : at least one mismatch was recorded.
//   result_map     (out, 2^N_IN): bit v holds the gate output sampled for vector v.
// -----------------------------------------------------------------------------
module gate_sweep_checker
    import sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned MODE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      gate_in,
    input  logic                 gate_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail_vec,
    output logic                 fail_seen,
    output logic [(1<<N_IN)-1:0] result_map
);

    localparam int unsigned NV    = 1 << N_IN;
    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [N_IN:0]    VEC_LAST   = (N_IN + 1)'(NV - 1);

    state_e            state_q, state_d;
    logic [N_IN:0]     vec_q, vec_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              fs_q, fs_d;
    logic [NV-1:0]     map_q, map_d;

    logic              exp_bit;
    logic              start_accept;

    sweep_expect #(
        .N_IN (N_IN),
        .MODE (MODE)
    ) u_expect (
        .vec     (vec_q[N_IN-1:0]),
        .exp_bit (exp_bit)
    );

    // A start is taken only when no sweep is running. A start during a sweep
    // has no effect.
    assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: vector, settle counter and scoreboard
    always_comb begin
        vec_d = vec_q;
        cnt_d = cnt_q;
        err_d = err_q;
        ff_d  = ff_q;
        fs_d  = fs_q;
        map_d = map_q;

        if (start_accept) begin
            vec_d = '0;
            cnt_d = CNT_RELOAD;
            err_d = '0;
            ff_d  = '0;
            fs_d  = 1'b0;
            map_d = '0;
        end else if (state_q == ST_SETTLE) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (state_q == ST_SAMPLE) begin
            map_d[vec_q[N_IN-1:0]] = gate_out;
            if (gate_out != exp_bit) begin
                // err_count can reach 2^N_IN, which fits in N_IN+1 bits.
                err_d = err_q + (N_IN + 1)'(1);
                if (!fs_q) begin
                    ff_d = vec_q[N_IN-1:0];
                    fs_d = 1'b1;
                end
            end
            // vec stops at the last vector so that gate_in keeps it in DONE.
            if (vec_q != VEC_LAST) begin
                vec_d = vec_q + (N_IN + 1)'(1);
                cnt_d = CNT_RELOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            ff_q  <= '0;
            fs_q  <= 1'b0;
            map_q <= '0;
        end else begin
            vec_q <= vec_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            ff_q  <= ff_d;
            fs_q  <= fs_d;
            map_q <= map_d;
        end
    end

    // Outputs
    always_comb begin
        gate_in        = vec_q[N_IN-1:0];
        busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
        done           = (state_q == ST_DONE);
        pass           = (state_q == ST_DONE) && (err_q == '0);
        err_count      = err_q;
        first_fail_vec = ff_q;
        fail_seen      = fs_q;
        result_map     = map_q;
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_checker
// Drives three checker instances: OR with SETTLE=2, AND with SETTLE=2 and OR
// with SETTLE=1. Each instance is wrapped around a modelled 3-input gate, which
// is either a correct OR3 or tied to 0 or 1. For each sweep the bench queues
// the expected result. It takes that result from the queue and compares it
// when done rises.
// -----------------------------------------------------------------------------
module tb_gate_sweep_checker;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      start;
    int              gate_sel;   // 0 = correct or3, 1 = tied 0, 2 = tied 1

    logic [2:0][2:0] gin;
    logic [2:0]      gout;
    logic [2:0]      busy, done, pass, fseen;
    logic [2:0][3:0] errc;
    logic [2:0][2:0] ffv;
    logic [2:0][7:0] rmap;

    typedef struct {
        int         lat;
        logic [3:0] err;
        logic [2:0] ff;
        logic       fs;
        logic [7:0] map;
        logic       pass;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic gate_model(input logic [2:0] v);
        if (gate_sel == 0) return v[0] | v[1] | v[2];
        return (gate_sel == 2);
    endfunction

    assign gout[0] = gate_model(gin[0]);
    assign gout[1] = gate_model(gin[1]);
    assign gout[2] = gate_model(gin[2]);

    gate_sweep_checker #(.N_IN(3), .SETTLE(2), .MODE(0)) dut_or (
        .clk(clk), .rst(rst), .start(start[0]), .gate_in(gin[0]), .gate_out(gout[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
        .first_fail_vec(ffv[0]), .fail_seen(fseen[0]), .result_map(rmap[0])
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(2), .MODE(1)) dut_and (
        .clk(clk), .rst(rst), .start(start[1]), .gate_in(gin[1]), .gate_out(gout[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
        .first_fail_vec(ffv[1]), .fail_seen(fseen[1]), .result_map(rmap[1])
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(1), .MODE(0)) dut_s1 (
        .clk(clk), .rst(rst), .start(start[2]), .gate_in(gin[2]), .gate_out(gout[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
        .first_fail_vec(ffv[2]), .fail_seen(fseen[2]), .result_map(rmap[2])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int sel, input int mode, input int settle);
        exp_t e;
        logic g, x;
        logic [2:0] v;
        e.lat = 8 * (settle + 1);
        e.err = 0; e.ff = 0; e.fs = 0; e.map = 0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            g = (sel == 0) ? (i != 0) : (sel == 2);
            case (mode)
                0:       x = (i != 0);
                1:       x = (i == 7);
                2:       x = v[0] ^ v[1] ^ v[2];
                default: x = (i == 0);
            endcase
            e.map[i] = g;
            if (g != x) begin
                e.err = e.err + 4'd1;
                if (!e.fs) begin
                    e.ff = v;
                    e.fs = 1'b1;
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic check_idle_outputs(input int idx, input string pfx);
        check_eq({pfx, "_busy"}, 32'(busy[idx]), 0);
        check_eq({pfx, "_done"}, 32'(done[idx]), 0);
        check_eq({pfx, "_pass"}, 32'(pass[idx]), 0);
        check_eq({pfx, "_err"},  32'(errc[idx]), 0);
        check_eq({pfx, "_ff"},   32'(ffv[idx]),  0);
        check_eq({pfx, "_fs"},   32'(fseen[idx]), 0);
        check_eq({pfx, "_map"},  32'(rmap[idx]), 0);
        check_eq({pfx, "_gin"},  32'(gin[idx]),  0);
    endtask

    // One sweep on instance idx. restart_at pulses start again that many edges
    // after the accept edge. rst_at aborts the sweep with a reset instead.
    task automatic run_sweep(input int idx, input int sel, input int mode, input int settle,
                             input int restart_at, input int rst_at);
        exp_t e;
        int   cyc;
        gate_sel = sel;
        if (rst_at < 0) sb.push_back(model(sel, mode, settle));
        @(negedge clk);
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        // Sweep started and results cleared
        check_eq("start_busy", 32'(busy[idx]), 1);
        check_eq("start_done", 32'(done[idx]), 0);
        check_eq("start_err",  32'(errc[idx]), 0);
        check_eq("start_map",  32'(rmap[idx]), 0);
        check_eq("start_fs",   32'(fseen[idx]), 0);
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == rst_at) begin
                check_eq("pre_rst_gin",  32'(gin[idx]),  4);
                check_eq("pre_rst_busy", 32'(busy[idx]), 1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle_outputs(idx, "midrst");
                return;
            end
            if (done[idx]) break;
            start[idx] = (cyc == restart_at);
        end
        start[idx] = 1'b0;
        if (!done[idx]) begin
            check_eq("done_timeout", 32'(done[idx]), 1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check_eq("latency",   32'(cyc),        32'(e.lat));
        check_eq("busy_done", 32'(busy[idx]),  0);
        check_eq("pass",      32'(pass[idx]),  32'(e.pass));
        check_eq("err_count", 32'(errc[idx]),  32'(e.err));
        check_eq("first_ff",  32'(ffv[idx]),   32'(e.ff));
        check_eq("fail_seen", 32'(fseen[idx]), 32'(e.fs));
        check_eq("result_map",32'(rmap[idx]),  32'(e.map));
        check_eq("gin_hold",  32'(gin[idx]),   7);
    endtask

    initial begin
        rst      = 1'b1;
        start    = '0;
        gate_sel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs(0, "reset");

        run_sweep(0, 0, 0, 2, -1, -1);   // correct or3
        run_sweep(0, 1, 0, 2, -1, -1);   // tied 0, started from DONE
        run_sweep(0, 2, 0, 2, -1, -1);   // tied 1
        run_sweep(1, 0, 1, 2, -1, -1);   // or3 checked as AND
        run_sweep(0, 0, 0, 2, -1, 13);   // reset while vec=4 settles
        run_sweep(0, 0, 0, 2, -1, -1);   // clean pass after reset
        run_sweep(0, 0, 0, 2, 10, -1);   // start pulsed mid-sweep
        run_sweep(2, 0, 0, 1, 5, -1);    // SETTLE=1 with mid-sweep start
        run_sweep(2, 1, 0, 1, -1, -1);   // SETTLE=1, tied 0

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-checking stimulus/capture stage placed directly upstream of, and wrapped around, a small N-input combinational gate (e.g. or3).
- On a start pulse it drives every input combination 0..2^N_IN-1 onto the gate in ascending order. It waits a programmable settle time for each vector, then samples the gate output.
- It compares each sample against the expected function, builds the captured truth table, and reports pass/fail, error count and the first failing vector.
- Replaces hand-written $display sweeps with a synthesizable, cycle-exact checker.

Parameters:
- N_IN, 3, number of gate inputs (1..6).
- SETTLE, 2, cycles gate_in is held before sampling (>=1).
- MODE, 0, expected function: 0=OR, 1=AND, 2=XOR, 3=NOR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep.
- gate_in  out  N_IN  vector driven to the gate under test.
- gate_out  in  1  gate output being checked.
- busy  out  1  high while a sweep is in progress.
- done  out  1  level, high in DONE state.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors.
- first_fail_vec  out  N_IN  first mismatching vector; valid when fail_seen=1.
- fail_seen  out  1  at least one mismatch recorded.
- result_map  out  2^N_IN  captured truth table; bit v = gate_out sampled for vector v.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- rst=1 at a clock edge forces all of the following on that edge, including mid-sweep:
  - state=IDLE.
  - gate_in=0, busy=0, done=0, pass=0, fail_seen=0.
  - err_count=0, first_fail_vec=0, result_map=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1: go to SETTLE, vec=0, settle counter=SETTLE-1. Clear result_map, err_count, fail_seen, first_fail_vec and pass. busy=1.
- SETTLE: gate_in=vec. Counter decrements each cycle; at counter==0 go to SAMPLE. SETTLE therefore lasts exactly SETTLE cycles.
- SAMPLE (one cycle): on the edge leaving SAMPLE:
  - result_map[vec] <= gate_out.
  - If gate_out != expect(MODE, vec): err_count += 1. If fail_seen==0, also set first_fail_vec=vec and fail_seen=1.
  - If vec == 2^N_IN-1: go to DONE. Otherwise vec+1 and go to SETTLE with the counter reloaded.
- DONE:
  - busy=0, done=1, pass = (err_count==0).
  - gate_in holds the last vector.
  - Remains in DONE until start=1, which restarts exactly as from IDLE (done drops on that edge).
- start while busy: ignored, with no effect on the sweep.
- Latency: done rises exactly 2^N_IN*(SETTLE+1) cycles after the start-accept edge (24 for defaults).
- Width: err_count maximum is 2^N_IN, which fits in N_IN+1 bits, so no saturation is needed.
- vec is N_IN+1 bits internally; the increment past the last vector never occurs.
- Expected function is the reduction over vec: OR, AND, XOR, or NOT-OR.
- gate_out is sampled only in SAMPLE; it is a don't-care otherwise.

Decomposition:
- Package sweep_pkg:
  - state enum (IDLE/SETTLE/SAMPLE/DONE).
  - MODE constants (MODE_OR, MODE_AND, MODE_XOR, MODE_NOR).
  - Function expect_bit(mode, vec).
- One sub-module, sweep_expect: combinational, parameterized on N_IN/MODE, maps vec to the expected bit. It is reused by later gate checkers.
- FSM, counters and scoreboard stay in gate_sweep_checker.

Test Plan:
- Correct or3 attached, defaults, start pulse -> done 24 cycles later, pass=1, err_count=0, result_map=8'hFE, fail_seen=0.
- gate_out tied 0, MODE=0 -> err_count=7, first_fail_vec=1, fail_seen=1, result_map=8'h00, pass=0.
- gate_out tied 1, MODE=0 -> err_count=1, first_fail_vec=0, result_map=8'hFF, pass=0.
- Correct or3 attached with MODE=1 (AND) -> err_count=6, first_fail_vec=1, result_map=8'hFE.
- rst asserted while vec=4 in SETTLE -> next edge all outputs reset; new start then gives a clean pass in 24 cycles.
- start re-pulsed mid-sweep -> ignored, done still at cycle 24; start pulsed in DONE -> done drops, results cleared, new sweep completes 24 cycles later. Repeat with SETTLE=1 -> done at 16 cycles.
